// File: rtl/gardner_ctrl_pkg.sv
// Shared constants and state encoding for the Gardner timing-loop sequencer.
package gardner_ctrl_pkg;

    localparam int unsigned ERR_W       = 16;
    localparam int unsigned WIN_LOG2    = 4;
    localparam int unsigned ACC_W       = ERR_W + WIN_LOG2;

    localparam int unsigned FLUSH_CYC   = 8;
    localparam int unsigned LOCK_WINS   = 3;
    localparam int unsigned UNLOCK_WINS = 2;
    localparam int unsigned ACQ_TIMEOUT = 64;

    localparam int unsigned FLUSH_W = $clog2(FLUSH_CYC);
    localparam int unsigned GOOD_W  = $clog2(LOCK_WINS + 1);
    localparam int unsigned BAD_W   = $clog2(UNLOCK_WINS + 1);
    localparam int unsigned WCNT_W  = $clog2(ACQ_TIMEOUT + 1);

    localparam logic [ERR_W-1:0] LOCK_THR   = ERR_W'(2048);
    localparam logic [ERR_W-1:0] UNLOCK_THR = ERR_W'(4096);

    localparam logic [4:0] KP_ACQ = 5'd4;
    localparam logic [4:0] KI_ACQ = 5'd8;
    localparam logic [4:0] KP_TRK = 5'd6;
    localparam logic [4:0] KI_TRK = 5'd12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_ACQ   = 2'd2,
        ST_TRACK = 2'd3
    } state_e;

endpackage

// File: rtl/err_mag_window.sv
// Windowed mean of |timing error|: saturating abs, accumulator, sample counter, window result.
module err_mag_window
    import gardner_ctrl_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    input  logic                    acc_en_i,
    input  logic                    valid_i,
    input  logic signed [ERR_W-1:0] err_i,
    output logic                    win_done_o,
    output logic [ERR_W-1:0]        win_mean_o,
    output logic [ERR_W-1:0]        win_mag_o
);

    localparam logic [ERR_W-1:0] MAG_MAX = {1'b0, {(ERR_W-1){1'b1}}};
    localparam logic [ERR_W-1:0] MAG_MIN = {1'b1, {(ERR_W-1){1'b0}}};

    logic [ERR_W-1:0]    mag;
    logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0]    win_mag_q, win_mag_d;

    // Abs with the most negative code clamped, then running sum and window bookkeeping.
    always_comb begin
        if (err_i == MAG_MIN) begin
            mag = MAG_MAX;
        end else if (err_i[ERR_W-1]) begin
            mag = $unsigned(-err_i);
        end else begin
            mag = $unsigned(err_i);
        end

        acc_sum    = acc_q + ACC_W'(mag);
        // Mean includes the sample arriving on the closing cycle.
        win_mean_o = acc_sum[ACC_W-1:WIN_LOG2];
        win_done_o = acc_en_i & valid_i & (&cnt_q);

        acc_d     = acc_q;
        cnt_d     = cnt_q;
        win_mag_d = win_done_o ? win_mean_o : win_mag_q;

        if (clr_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (acc_en_i && valid_i) begin
            if (win_done_o) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Accumulator, sample counter and last-window result registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            win_mag_q <= '0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            win_mag_q <= win_mag_d;
        end
    end

    assign win_mag_o = win_mag_q;

endmodule

// File: rtl/gardner_loop_ctrl.sv
// Gardner timing-loop sequencer: flush, wide-gain acquisition, lock detect, narrow-gain tracking.
module gardner_loop_ctrl
    import gardner_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic signed [ERR_W-1:0] err,
    input  logic                    err_valid,
    output logic                    loop_clr,
    output logic                    loop_en,
    output logic [4:0]              kp_shift,
    output logic [4:0]              ki_shift,
    output logic                    locked,
    output logic [1:0]              state,
    output logic [ERR_W-1:0]        win_mag
);

    state_e              state_q, state_d;
    logic [FLUSH_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d, good_nxt;
    logic [BAD_W-1:0]    bad_cnt_q, bad_cnt_d, bad_nxt;
    logic [WCNT_W-1:0]   win_cnt_q, win_cnt_d, win_nxt;
    logic                state_entry;
    logic                acc_en;
    logic                win_done;
    logic [ERR_W-1:0]    win_mean;

    logic                loop_clr_q, loop_clr_d;
    logic                loop_en_q, loop_en_d;
    logic [4:0]          kp_q, kp_d, ki_q, ki_d;
    logic                locked_q, locked_d;

    assign acc_en = (state_q == ST_ACQ) || (state_q == ST_TRACK);

    err_mag_window u_win (
        .clk_i      (clk),
        .rst_ni     (reset),
        .clr_i      (state_entry),
        .acc_en_i   (acc_en),
        .valid_i    (err_valid),
        .err_i      (err),
        .win_done_o (win_done),
        .win_mean_o (win_mean),
        .win_mag_o  (win_mag)
    );

    // Next state and window counters; disable overrides everything, any state change clears counts.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        win_cnt_d   = win_cnt_q;

        good_nxt = (win_mean < LOCK_THR) ? good_cnt_q + 1'b1 : '0;
        bad_nxt  = (win_mean > UNLOCK_THR) ? bad_cnt_q + 1'b1 : '0;
        win_nxt  = win_cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: state_d = ST_FLUSH;
            ST_FLUSH: begin
                if (flush_cnt_q == FLUSH_W'(FLUSH_CYC - 1)) begin
                    state_d = ST_ACQ;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            ST_ACQ: begin
                if (win_done) begin
                    good_cnt_d = good_nxt;
                    win_cnt_d  = win_nxt;
                    // Lock is tested first so it wins over a simultaneous timeout.
                    if (good_nxt == GOOD_W'(LOCK_WINS)) begin
                        state_d = ST_TRACK;
                    end else if (win_nxt == WCNT_W'(ACQ_TIMEOUT)) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_TRACK: begin
                if (win_done) begin
                    bad_cnt_d = bad_nxt;
                    if (bad_nxt == BAD_W'(UNLOCK_WINS)) begin
                        state_d = ST_ACQ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!enable) begin
            state_d = ST_IDLE;
        end

        state_entry = (state_d != state_q);
        if (state_entry) begin
            flush_cnt_d = '0;
            good_cnt_d  = '0;
            bad_cnt_d   = '0;
            win_cnt_d   = '0;
        end
    end

    // Outputs decoded from the next state so the registered copies track the state register.
    always_comb begin
        loop_clr_d = 1'b1;
        loop_en_d  = 1'b0;
        kp_d       = KP_ACQ;
        ki_d       = KI_ACQ;
        locked_d   = 1'b0;
        case (state_d)
            ST_ACQ: begin
                loop_clr_d = 1'b0;
                loop_en_d  = 1'b1;
            end
            ST_TRACK: begin
                loop_clr_d = 1'b0;
                loop_en_d  = 1'b1;
                kp_d       = KP_TRK;
                ki_d       = KI_TRK;
                locked_d   = 1'b1;
            end
            default: ;
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            win_cnt_q   <= '0;
            loop_clr_q  <= 1'b1;
            loop_en_q   <= 1'b0;
            kp_q        <= KP_ACQ;
            ki_q        <= KI_ACQ;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            win_cnt_q   <= win_cnt_d;
            loop_clr_q  <= loop_clr_d;
            loop_en_q   <= loop_en_d;
            kp_q        <= kp_d;
            ki_q        <= ki_d;
            locked_q    <= locked_d;
        end
    end

    assign state    = state_q;
    assign loop_clr = loop_clr_q;
    assign loop_en  = loop_en_q;
    assign kp_shift = kp_q;
    assign ki_shift = ki_q;
    assign locked   = locked_q;

endmodule

// File: tb/tb_gardner_loop_ctrl.sv
// Self-checking bench for gardner_loop_ctrl: vector table, directed corner cases, random vs model.
module tb_gardner_loop_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] err = '0;
    logic        err_valid = 1'b0;
    logic        loop_clr, loop_en, locked;
    logic [4:0]  kp_shift, ki_shift;
    logic [1:0]  state;
    logic [15:0] win_mag;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    gardner_loop_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .err       (err),
        .err_valid (err_valid),
        .loop_clr  (loop_clr),
        .loop_en   (loop_en),
        .kp_shift  (kp_shift),
        .ki_shift  (ki_shift),
        .locked    (locked),
        .state     (state),
        .win_mag   (win_mag)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, got, exp);
    endtask

    // Reference model: state number, plain counters and a list of window samples.
    int m_st, m_flush, m_good, m_bad, m_wins, m_wm;
    int m_win[$];

    function automatic int abs_sat(input logic [15:0] d);
        int v;
        v = int'($signed(d));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    task automatic model_reset();
        m_st = 0; m_flush = 0; m_good = 0; m_bad = 0; m_wins = 0; m_wm = 0;
        m_win.delete();
    endtask

    task automatic model_step(input logic r, input logic e, input logic [15:0] d, input logic v);
        int ns, sum, mean;
        bit win;
        if (!r) begin
            model_reset();
            return;
        end
        ns = m_st; win = 0; mean = 0;
        if ((m_st == 2 || m_st == 3) && v) begin
            m_win.push_back(abs_sat(d));
            if (m_win.size() == 16) begin
                sum = 0;
                foreach (m_win[i]) sum += m_win[i];
                mean = sum / 16;
                m_wm = mean;
                m_win.delete();
                win = 1;
            end
        end
        if (!e) ns = 0;
        else begin
            case (m_st)
                0: ns = 1;
                1: begin
                    m_flush++;
                    if (m_flush == 8) ns = 2;
                end
                2: if (win) begin
                    m_wins++;
                    m_good = (mean < 2048) ? m_good + 1 : 0;
                    if (m_good == 3) ns = 3;
                    else if (m_wins == 64) ns = 1;
                end
                default: if (win) begin
                    m_bad = (mean > 4096) ? m_bad + 1 : 0;
                    if (m_bad == 2) ns = 2;
                end
            endcase
        end
        if (ns != m_st) begin
            m_win.delete();
            m_flush = 0; m_good = 0; m_bad = 0; m_wins = 0;
        end
        m_st = ns;
    endtask

    function automatic logic [30:0] model_outs();
        logic [4:0] kp, ki;
        kp = (m_st == 3) ? 5'd6 : 5'd4;
        ki = (m_st == 3) ? 5'd12 : 5'd8;
        return {2'(m_st), m_st < 2, m_st >= 2, kp, ki, m_st == 3, 16'(m_wm)};
    endfunction

    // One clock: drive, advance the model at the edge, compare shortly after.
    task automatic step(input logic r, input logic e, input logic [15:0] d, input logic v);
        reset = r; enable = e; err = d; err_valid = v;
        @(posedge clk);
        model_step(r, e, d, v);
        #1;
        check("cycle", {1'b0, state, loop_clr, loop_en, kp_shift, ki_shift, locked, win_mag},
              {1'b0, model_outs()});
    endtask

    task automatic go_to_acq();
        step(1'b1, 1'b0, 16'd0, 1'b0);
        repeat (9) step(1'b1, 1'b1, 16'd0, 1'b0);
        check("acq_entry", 32'(state), 32'd2);
    endtask

    task automatic go_to_track();
        go_to_acq();
        repeat (48) step(1'b1, 1'b1, 16'd0, 1'b1);
        check("track_entry", 32'(state), 32'd3);
    endtask

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [15:0] e;
        logic        vld;
        logic [1:0]  st;
        logic        clr;
        logic        len;
        logic [4:0]  kp;
        logic [4:0]  ki;
        logic        lk;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int nflush, nerr, amp;
        bit got;
        logic [15:0] d;
        logic e, r, v;

        model_reset();

        // Reset, idle, flush length and ACQ entry; valid errors in FLUSH must be ignored.
        vecs[0] = '{1'b0, 1'b1, 16'd0, 1'b0, 2'd0, 1'b1, 1'b0, 5'd4, 5'd8, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'd0, 1'b0, 2'd0, 1'b1, 1'b0, 5'd4, 5'd8, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 16'd0, 1'b1, 2'd0, 1'b1, 1'b0, 5'd4, 5'd8, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 16'd0, 1'b0, 2'd1, 1'b1, 1'b0, 5'd4, 5'd8, 1'b0};
        for (int i = 4; i <= 10; i++)
            vecs[i] = '{1'b1, 1'b1, 16'd8000, 1'b1, 2'd1, 1'b1, 1'b0, 5'd4, 5'd8, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 16'd0, 1'b0, 2'd2, 1'b0, 1'b1, 5'd4, 5'd8, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 16'd0, 1'b0, 2'd0, 1'b1, 1'b0, 5'd4, 5'd8, 1'b0};

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].rst_n, vecs[i].en, vecs[i].e, vecs[i].vld);
            check($sformatf("vec%0d", i),
                  {16'd0, vecs[i].st, vecs[i].clr, vecs[i].len, vecs[i].kp, vecs[i].ki,
                   vecs[i].lk, 1'b0},
                  {16'd0, state, loop_clr, loop_en, kp_shift, ki_shift, locked, 1'b0});
            check($sformatf("vec%0d_winmag", i), 32'(win_mag), 32'd0);
        end

        // Acquisition with zero error on every other clock.
        step(1'b1, 1'b0, 16'd0, 1'b0);
        nflush = 0; nerr = 0; got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            v = i[0];
            if (m_st == 2 && v) nerr++;
            step(1'b1, 1'b1, 16'd0, v);
            if (state == 2'd1) nflush++;
            if (state == 2'd3) got = 1;
        end
        check("lock_reached", 32'(got), 32'd1);
        check("flush_cycles", 32'(nflush), 32'd8);
        check("lock_errs", 32'(nerr), 32'd48);
        check("trk_gains", {22'd0, kp_shift, ki_shift}, {22'd0, 5'd6, 5'd12});

        // Bad windows in TRACK drop back to ACQ after the second one.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, i[0] ? -16'sd5000 : 16'sd5000, 1'b1);
        check("bad_win_mag", 32'(win_mag), 32'd5000);
        check("bad_win1_state", 32'(state), 32'd3);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, i[0] ? -16'sd5000 : 16'sd5000, 1'b1);
        check("unlock_state", {29'd0, state, locked}, {29'd0, 2'd2, 1'b0});
        check("unlock_gains", {22'd0, kp_shift, ki_shift}, {22'd0, 5'd4, 5'd8});

        // Constant mid-level error never locks; window 64 forces a re-flush.
        go_to_acq();
        repeat (1023) step(1'b1, 1'b1, 16'd3000, 1'b1);
        check("pre_timeout", 32'(state), 32'd2);
        step(1'b1, 1'b1, 16'd3000, 1'b1);
        check("timeout_flush", 32'(state), 32'd1);
        repeat (8) step(1'b1, 1'b1, 16'd0, 1'b0);
        check("reacq", 32'(state), 32'd2);

        // Most negative error saturates.
        go_to_acq();
        repeat (16) step(1'b1, 1'b1, 16'h8000, 1'b1);
        check("sat_winmag", 32'(win_mag), 32'd32767);
        check("sat_state", 32'(state), 32'd2);

        // Disable on the lock-completing sample wins.
        go_to_acq();
        repeat (47) step(1'b1, 1'b1, 16'd0, 1'b1);
        step(1'b1, 1'b0, 16'd0, 1'b1);
        check("dis_on_lock", {30'd0, state, locked} >> 0, {29'd0, 2'd0, 1'b0});

        // Asynchronous reset mid-TRACK takes effect without a clock edge.
        go_to_track();
        #3 reset = 1'b0;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_ctl", {30'd0, loop_clr, loop_en}, {30'd0, 1'b1, 1'b0});
        check("arst_locked", 32'(locked), 32'd0);
        check("arst_gains", {22'd0, kp_shift, ki_shift}, {22'd0, 5'd4, 5'd8});
        model_reset();
        step(1'b0, 1'b1, 16'd0, 1'b0);
        step(1'b1, 1'b0, 16'd0, 1'b0);
        step(1'b1, 1'b0, 16'd0, 1'b0);
        check("no_resume", 32'(state), 32'd0);
        step(1'b1, 1'b1, 16'd0, 1'b0);
        check("resume", 32'(state), 32'd1);

        // Random traffic against the model.
        amp = 1500;
        for (int i = 0; i < 6000; i++) begin
            if (i % 128 == 0) begin
                case ($urandom_range(0, 4))
                    0, 1: amp = 1500;
                    2: amp = 3000;
                    3: amp = 6000;
                    default: amp = 32768;
                endcase
            end
            d = 16'($urandom_range(0, amp));
            if ($urandom_range(0, 1) == 1) d = -d;
            v = ($urandom_range(0, 1) == 1);
            e = ($urandom_range(0, 499) != 0);
            r = ($urandom_range(0, 1999) != 0);
            step(r, e, d, v);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
